multicycle_control_unit: RTL

//  Multi-cycle successor to the single-cycle decoder. FSM sequences FETCH/DECODE/EXEC/MEM/WB
//  and holds the fetched instruction internally. Adds full B-type set, JALR, LUI, AUIPC, LW/SW

---
 rtl/multicycle_control_unit.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, holds the instruction
// register, decodes datapath controls and tracks traps and retired instructions.
module multicycle_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned EN_JALR     = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             imem_ready,
    input  logic [31:0]      instr,
    input  logic             br_eq,
    input  logic             br_lt,
    input  logic             br_ltu,
    input  logic             dmem_ready,
    input  logic             trap_clr,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             prf_wr_en,
    output logic             pc_wr_en,
    output logic [2:0]       cu_imm_sel,
    output logic             prf_pc_mux_ctrl,
    output logic             prf_imm_mux_ctrl,
    output logic [3:0]       cu_alu_ctrl,
    output logic [1:0]       cu_mem_out_mux_sel,
    output logic             branch_taken,
    output logic             jalr_sel,
    output logic             illegal_instr,
    output logic             mem_fault,
    output logic             instr_retired,
    output logic [CNT_W-1:0] instret,
    output logic [2:0]       state_o
);

    localparam logic [2:0] ImmI  = 3'd0;
    localparam logic [2:0] ImmS  = 3'd1;
    localparam logic [2:0] ImmB  = 3'd2;
    localparam logic [2:0] ImmU  = 3'd3;
    localparam logic [2:0] ImmJ  = 3'd4;

    localparam logic [3:0] AluAdd = 4'b0000;

    localparam logic [1:0] SelAlu = 2'b00;
    localparam logic [1:0] SelMem = 2'b01;
    localparam logic [1:0] SelPc4 = 2'b10;
    localparam logic [1:0] SelImm = 2'b11;

    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    localparam logic [31:0] Nop = 32'h0000_0013;

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StTrap   = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       ir_q, ir_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]  instret_q;
    logic              illegal_q, illegal_d;
    logic              fault_q, fault_d;
    logic              retire;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       is_branch, is_load, is_store, is_jal, is_jalr;
    logic       illegal, br_cond;
    logic       unused_ir;

    assign opcode    = ir_q[6:0];
    assign rd        = ir_q[11:7];
    assign funct3    = ir_q[14:12];
    assign funct7    = ir_q[31:25];
    assign unused_ir = ^ir_q[24:15];

    assign is_branch = (opcode == OpBranch);
    assign is_load   = (opcode == OpLoad);
    assign is_store  = (opcode == OpStore);
    assign is_jal    = (opcode == OpJal);
    assign is_jalr   = (opcode == OpJalr) && (EN_JALR != 0);

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OpImm, OpLui, OpAuipc, OpJal: illegal = 1'b0;
            OpReg: begin
                if (funct7 == 7'b0100000) begin
                    illegal = !((funct3 == 3'b000) || (funct3 == 3'b101));
                end else begin
                    illegal = (funct7 != 7'b0000000);
                end
            end
            OpBranch:        illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            OpLoad, OpStore: illegal = (funct3 != 3'b010);
            OpJalr:          illegal = (EN_JALR == 0) || (funct3 != 3'b000);
            default:         illegal = 1'b1;
        endcase
    end

    always_comb begin
        br_cond = 1'b0;
        case (funct3)
            3'b000:  br_cond = br_eq;
            3'b001:  br_cond = !br_eq;
            3'b100:  br_cond = br_lt;
            3'b101:  br_cond = !br_lt;
            3'b110:  br_cond = br_ltu;
            3'b111:  br_cond = !br_ltu;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = cnt_q;
        illegal_d = illegal_q;
        fault_d   = fault_q;
        retire    = 1'b0;
        case (state_q)
            StIdle: begin
                if (en) state_d = StFetch;
            end
            StFetch: begin
                if (imem_ready) begin
                    ir_d    = instr;
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (illegal) begin
                    illegal_d = 1'b1;
                    state_d   = StTrap;
                end else begin
                    state_d = StExec;
                end
            end
            StExec: begin
                if (is_branch) begin
                    retire  = 1'b1;
                    state_d = en ? StFetch : StIdle;
                end else if (is_load || is_store) begin
                    cnt_d   = '0;
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                // A ready on the final allowed cycle still completes the access.
                if (dmem_ready) begin
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = en ? StFetch : StIdle;
                    end else begin
                        state_d = StWb;
                    end
                end else if (cnt_q == CntLast) begin
                    fault_d = 1'b1;
                    state_d = StTrap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWb: begin
                retire  = 1'b1;
                state_d = en ? StFetch : StIdle;
            end
            StTrap: begin
                if (trap_clr) begin
                    illegal_d = 1'b0;
                    fault_d   = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            ir_q      <= Nop;
            cnt_q     <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            fault_q   <= fault_d;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    always_comb begin
        imem_req           = 1'b0;
        dmem_req           = 1'b0;
        dmem_we            = 1'b0;
        prf_wr_en          = 1'b0;
        pc_wr_en           = 1'b0;
        cu_imm_sel         = ImmI;
        prf_pc_mux_ctrl    = 1'b0;
        prf_imm_mux_ctrl   = 1'b1;
        cu_alu_ctrl        = AluAdd;
        cu_mem_out_mux_sel = SelAlu;
        branch_taken       = 1'b0;
        jalr_sel           = 1'b0;

        // Datapath steering follows the held instruction once it has been fetched.
        if (state_q inside {StDecode, StExec, StMem, StWb}) begin
            case (opcode)
                OpImm: begin
                    cu_alu_ctrl = (funct3 == 3'b101) ? {ir_q[30], funct3} : {1'b0, funct3};
                end
                OpReg: begin
                    prf_imm_mux_ctrl = 1'b0;
                    cu_alu_ctrl      = {ir_q[30], funct3};
                end
                OpLui: begin
                    cu_imm_sel         = ImmU;
                    cu_mem_out_mux_sel = SelImm;
                end
                OpAuipc: begin
                    prf_pc_mux_ctrl = 1'b1;
                    cu_imm_sel      = ImmU;
                end
                OpJal: begin
                    prf_pc_mux_ctrl    = 1'b1;
                    cu_imm_sel         = ImmJ;
                    cu_mem_out_mux_sel = SelPc4;
                end
                OpJalr: begin
                    cu_mem_out_mux_sel = SelPc4;
                end
                OpBranch: begin
                    prf_pc_mux_ctrl = 1'b1;
                    cu_imm_sel      = ImmB;
                end
                OpLoad: begin
                    cu_mem_out_mux_sel = SelMem;
                end
                OpStore: begin
                    cu_imm_sel = ImmS;
                end
                default: begin
                    cu_imm_sel = ImmI;
                end
            endcase
        end

        case (state_q)
            StFetch: imem_req = 1'b1;
            StExec: begin
                if (is_branch) begin
                    pc_wr_en     = 1'b1;
                    branch_taken = br_cond;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_wr_en = is_store && dmem_ready;
            end
            StWb: begin
                prf_wr_en    = (rd != 5'd0);
                pc_wr_en     = 1'b1;
                branch_taken = is_jal || is_jalr;
                jalr_sel     = is_jalr;
            end
            default: begin
                imem_req = 1'b0;
            end
        endcase
    end

    assign illegal_instr = illegal_q;
    assign mem_fault     = fault_q;
    assign instr_retired = retire;
    assign instret       = instret_q;
    assign state_o       = state_q;

endmodule
